spi_pixel_loader: RTL

//  Consumes the 12-bit pixel words and write-enable strobes from the SPI receiver (spiClk domain).

---
 rtl/edge_pkg.sv | 19 +
 rtl/pulse_sync.sv | 30 +++
 rtl/spi_pixel_loader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/edge_pkg.sv
// Shared types and defaults for the edge-detection front end.
package edge_pkg;

  typedef enum logic [1:0] {
    Idle,
    Load,
    Done
  } loader_state_t;

  localparam int unsigned PIX_W_DEF = 12;
  localparam int unsigned IMG_W_DEF = 160;
  localparam int unsigned IMG_H_DEF = 120;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 2) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/pulse_sync.sv
// Multi-flop synchronizer followed by a registered rising-edge detector.
// The output pulse is one clk cycle wide.
module pulse_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic din,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic                   pulse_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_q  <= '0;
      last_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      last_q  <= sync_q[SYNC_STAGES-1];
      pulse_q <= sync_q[SYNC_STAGES-1] & ~last_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/spi_pixel_loader.sv
// Moves SPI pixel words into the clk domain and writes them row-major into the frame buffer.
// Define SPI_LOADER_OVERRUN_CNT_EN to build the saturating overrun counter.
module spi_pixel_loader
  import edge_pkg::*;
#(
  parameter int unsigned IMG_W       = IMG_W_DEF,
  parameter int unsigned IMG_H       = IMG_H_DEF,
  parameter int unsigned PIX_W       = PIX_W_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned ADDR_W     = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [PIX_W-1:0]  spi_data,
  input  logic              spi_we,
  input  logic              frame_start,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun,
  output logic [7:0]        overrun_cnt
);

  localparam int unsigned COL_W = clog2_min1(IMG_W);
  localparam int unsigned ROW_W = clog2_min1(IMG_H);

  loader_state_t state_q, state_d;

  logic              pix_evt;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  wdata_q, wdata_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              frame_done_q, frame_done_d;
  logic              overrun_q, overrun_d;

  logic transfer;
  logic last_pix;
  logic in_load;
  logic accept;
  logic drop;

  // spi_data is left unsynchronized: the clock ratio keeps it stable across pix_evt.
  pulse_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_we_sync (
    .clk   (clk),
    .nreset(nreset),
    .din   (spi_we),
    .pulse (pix_evt)
  );

  assign transfer = mem_we_q & mem_ready;
  assign last_pix = (col_q == COL_W'(IMG_W - 1)) && (row_q == ROW_W'(IMG_H - 1));
  assign in_load  = (state_q == Load) && !frame_start;

  // A pixel arriving on the transfer edge is taken, unless that transfer ends the frame.
  assign accept = in_load && pix_evt && (!mem_we_q || (transfer && !last_pix));
  assign drop   = in_load && pix_evt && mem_we_q && !transfer;

  // FSM state register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= Idle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Idle: if (frame_start) state_d = Load;
      Load: if (!frame_start && transfer && last_pix) state_d = Done;
      Done: if (frame_start) state_d = Load;
      default: state_d = Idle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy       = (state_q == Load);
    mem_we     = mem_we_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    frame_done = frame_done_q;
    overrun    = overrun_q;
  end

  // Capture, address counters and handshake
  always_comb begin
    mem_we_d     = mem_we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = frame_done_q;
    overrun_d    = overrun_q;

    if (frame_start) begin
      mem_we_d     = 1'b0;
      addr_d       = '0;
      col_d        = '0;
      row_d        = '0;
      frame_done_d = 1'b0;
      overrun_d    = 1'b0;
    end else if (state_q == Load) begin
      if (transfer) begin
        mem_we_d = 1'b0;
        if (last_pix) begin
          // Hold the final address; the frame never wraps.
          frame_done_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (col_q == COL_W'(IMG_W - 1)) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      if (accept) begin
        mem_we_d = 1'b1;
        wdata_d  = spi_data;
      end
      if (drop) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mem_we_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      mem_we_q     <= mem_we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef SPI_LOADER_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ovr_cnt_q <= '0;
    end else if (frame_start) begin
      ovr_cnt_q <= '0;
    end else if (drop && (ovr_cnt_q != 8'hff)) begin
      ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
  end

  assign overrun_cnt = ovr_cnt_q;
`else
  assign overrun_cnt = 8'd0;
`endif

endmodule
